or1200_pcgen: RTL and testbench
===============================

OR1200_PCGEN -- requirements
Module: or1200_pcgen

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0100, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be synchronous, active-high reset.
REQ-004 icpu_adr_o  output  32  SHALL carry the fetch address to the IC; bits [1:0] always 2'b00.
REQ-005 icpu_cycstb_o  output  1  SHALL mark a valid fetch request.
REQ-006 icpu_sel_o  output  4  SHALL be constant 4'hf.
REQ-007 icpu_ack_i  input  1  SHALL signal fetch completion with valid data.
REQ-008 icpu_err_i  input  1  SHALL signal fetch completion with error.
REQ-009 genpc_freeze  input  1  SHALL stall the pipeline; the fetch stage holds its instruction.
REQ-010 genpc_refetch  input  1  SHALL request re-issue of the current address.
REQ-011 branch_taken  input  1  SHALL request a redirect to branch_addr.
REQ-012 branch_addr  input  32  SHALL be the branch target.
REQ-013 except_start  input  1  SHALL request a redirect to except_vector.
REQ-014 except_vector  input  32  SHALL be the exception handler address.
REQ-015 if_kill  output  1  SHALL pulse for one cycle when a completing response is discarded.
REQ-016 pc_cur  output  32  SHALL equal the address of the current or last issued request.

Function
REQ-017 States SHALL be IDLE, REQ, HOLD and DRAIN; cycstb_o SHALL be 1 in REQ and DRAIN and 0 in IDLE and HOLD.
REQ-018 Redirect priority SHALL be except_start > branch_taken > genpc_refetch > genpc_freeze > sequential advance.
REQ-019 Any redirect target SHALL have bits [1:0] forced to 2'b00 when loaded into pc.
REQ-020 IDLE SHALL always go to REQ on the next cycle; a redirect in IDLE SHALL load its target into pc.
REQ-021 REQ with ack, no redirect, no refetch, no freeze: pc <= pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0); state stays REQ, so back-to-back acks give one fetch per cycle.
REQ-022 REQ with ack and genpc_refetch, no redirect: pc SHALL be held and state SHALL stay REQ.
REQ-023 REQ with ack and freeze, no redirect: pc SHALL be held and state SHALL go to HOLD with the advance pending.
REQ-024 REQ with err, no redirect: pc SHALL be held and state SHALL go to HOLD with no advance pending.
REQ-025 REQ with ack or err plus redirect in the same cycle: the response SHALL be consumed with if_kill=0, pc <= target, and state SHALL stay REQ.
REQ-026 REQ with redirect and no ack/err: the target SHALL be stored and state SHALL go to DRAIN with pc unchanged.
REQ-027 DRAIN, new redirect, no ack/err: the stored target SHALL be overwritten by the higher-priority or newer target.
REQ-028 DRAIN with ack or err: if_kill=1 that cycle; pc <= stored target (or a same-cycle new redirect target); state SHALL go to REQ.
REQ-029 HOLD with redirect: pc <= target and state SHALL go to REQ.
REQ-030 HOLD, advance pending, freeze low: pc <= pc+4 and state SHALL go to REQ.
REQ-031 HOLD, no advance pending (err entry): state SHALL remain HOLD until a redirect arrives.
REQ-032 ack and err asserted together SHALL be treated as err.
REQ-033 ack/err in IDLE or HOLD SHALL be ignored.
REQ-034 icpu_adr_o SHALL equal pc_cur at all times.

Reset
REQ-035 While rst=1 the block SHALL hold: state IDLE, pc_cur = icpu_adr_o = RESET_VECTOR, icpu_cycstb_o=0, if_kill=0, stored target 0, advance-pending flag 0.
REQ-036 rst asserted mid-operation, including in DRAIN, SHALL override all inputs and discard any stored target on the next edge.

Verification
REQ-037 Reset release, ack held high -> cycstb_o=1 from cycle 2; addresses 0x100, 0x104, 0x108 on consecutive cycles.
REQ-038 pc=0xFFFF_FFFC, ack -> next icpu_adr_o = 0x0000_0000.
REQ-039 REQ at 0x200, branch_taken to 0x1003 without ack, ack 2 cycles later -> DRAIN; if_kill=1 on the ack cycle; next address 0x1000.
REQ-040 ack with genpc_freeze=1 at 0x300 for 3 cycles -> cycstb_o=0 during freeze; 0x304 issued the cycle after freeze drops.
REQ-041 err at 0x400 -> HOLD with cycstb_o=0 indefinitely; except_start to 0x600 -> next address 0x600.
REQ-042 In DRAIN, branch_taken and except_start together, then ack -> address goes to except_vector; rst during DRAIN -> address 0x100, if_kill=0.

Source files
------------

// File: rtl/or1200_pcgen.sv
// Instruction-fetch PC generator: issues fetch addresses to the instruction cache
// and redirects on branches/exceptions, discarding responses that arrive after a redirect.
module or1200_pcgen #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] icpu_adr_o,
  output logic        icpu_cycstb_o,
  output logic [3:0]  icpu_sel_o,
  input  logic        icpu_ack_i,
  input  logic        icpu_err_i,
  input  logic        genpc_freeze,
  input  logic        genpc_refetch,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        except_start,
  input  logic [31:0] except_vector,
  output logic        if_kill,
  output logic [31:0] pc_cur
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_target, w_target_nxt;
  logic        r_adv_pend, w_adv_pend_nxt;

  logic        w_redir;
  logic [31:0] w_redir_addr;
  logic        w_ack;
  logic        w_err;
  logic        w_resp;

  // Exceptions outrank branches; targets are always word aligned.
  assign w_redir      = except_start | branch_taken;
  assign w_redir_addr = except_start ? {except_vector[31:2], 2'b00}
                                     : {branch_addr[31:2], 2'b00};
  // A simultaneous ack and err is an error response.
  assign w_err  = icpu_err_i;
  assign w_ack  = icpu_ack_i & ~icpu_err_i;
  assign w_resp = w_ack | w_err;

  // State register. Reset is synchronous and clears any pending redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_VECTOR;
      r_target   <= '0;
      r_adv_pend <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_target   <= w_target_nxt;
      r_adv_pend <= w_adv_pend_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_target_nxt   = r_target;
    w_adv_pend_nxt = r_adv_pend;
    unique case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_REQ;
        if (w_redir) w_pc_nxt = w_redir_addr;
      end
      ST_REQ: begin
        if (w_resp && w_redir) begin
          w_pc_nxt = w_redir_addr;
        end else if (w_redir) begin
          w_target_nxt = w_redir_addr;
          w_state_nxt  = ST_DRAIN;
        end else if (w_err) begin
          w_adv_pend_nxt = 1'b0;
          w_state_nxt    = ST_HOLD;
        end else if (w_ack) begin
          if (genpc_refetch) begin
            w_pc_nxt = r_pc;
          end else if (genpc_freeze) begin
            w_adv_pend_nxt = 1'b1;
            w_state_nxt    = ST_HOLD;
          end else begin
            w_pc_nxt = r_pc + 32'd4;
          end
        end
      end
      ST_DRAIN: begin
        // The in-flight response belongs to the abandoned path.
        if (w_resp) begin
          w_pc_nxt    = w_redir ? w_redir_addr : r_target;
          w_state_nxt = ST_REQ;
        end else if (w_redir) begin
          w_target_nxt = w_redir_addr;
        end
      end
      ST_HOLD: begin
        if (w_redir) begin
          w_pc_nxt       = w_redir_addr;
          w_adv_pend_nxt = 1'b0;
          w_state_nxt    = ST_REQ;
        end else if (r_adv_pend && !genpc_freeze) begin
          w_pc_nxt       = r_pc + 32'd4;
          w_adv_pend_nxt = 1'b0;
          w_state_nxt    = ST_REQ;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    icpu_cycstb_o = (r_state == ST_REQ) || (r_state == ST_DRAIN);
    if_kill       = (r_state == ST_DRAIN) && w_resp && !rst;
    icpu_sel_o    = 4'hf;
    icpu_adr_o    = r_pc;
    pc_cur        = r_pc;
  end

endmodule

// File: tb/tb_or1200_pcgen.sv
// Directed-vector bench for or1200_pcgen with hand-computed expected addresses.
module tb_or1200_pcgen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] icpu_adr_o;
  logic        icpu_cycstb_o;
  logic [3:0]  icpu_sel_o;
  logic        icpu_ack_i;
  logic        icpu_err_i;
  logic        genpc_freeze;
  logic        genpc_refetch;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        except_start;
  logic [31:0] except_vector;
  logic        if_kill;
  logic [31:0] pc_cur;

  int checks = 0;
  int errors = 0;

  or1200_pcgen #(.RESET_VECTOR(32'h0000_0100)) dut (
    .clk           (clk),
    .rst           (rst),
    .icpu_adr_o    (icpu_adr_o),
    .icpu_cycstb_o (icpu_cycstb_o),
    .icpu_sel_o    (icpu_sel_o),
    .icpu_ack_i    (icpu_ack_i),
    .icpu_err_i    (icpu_err_i),
    .genpc_freeze  (genpc_freeze),
    .genpc_refetch (genpc_refetch),
    .branch_taken  (branch_taken),
    .branch_addr   (branch_addr),
    .except_start  (except_start),
    .except_vector (except_vector),
    .if_kill       (if_kill),
    .pc_cur        (pc_cur)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled well after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_fetch(input string tag, input logic [31:0] adr, input logic stb);
    #1;
    check({tag, "_adr"}, icpu_adr_o, adr);
    check({tag, "_pc"}, pc_cur, adr);
    check({tag, "_stb"}, {31'd0, icpu_cycstb_o}, {31'd0, stb});
  endtask

  task automatic chk_kill(input string tag, input logic exp);
    #1;
    check(tag, {31'd0, if_kill}, {31'd0, exp});
  endtask

  task automatic do_branch_ack(input logic [31:0] tgt);
    icpu_ack_i = 1'b1; branch_taken = 1'b1; branch_addr = tgt;
    tick();
    branch_taken = 1'b0;
  endtask

  initial begin
    rst = 1'b1; icpu_ack_i = 1'b0; icpu_err_i = 1'b0;
    genpc_freeze = 1'b0; genpc_refetch = 1'b0;
    branch_taken = 1'b0; branch_addr = '0;
    except_start = 1'b0; except_vector = '0;

    // Reset, then sequential fetch with ack held high.
    icpu_ack_i = 1'b1;
    tick(); tick();
    chk_fetch("rst", 32'h100, 1'b0);
    chk_kill("rst_kill", 1'b0);
    check("sel", {28'd0, icpu_sel_o}, 32'hf);
    rst = 1'b0;
    chk_fetch("idle", 32'h100, 1'b0);
    tick(); chk_fetch("seq0", 32'h100, 1'b1);
    tick(); chk_fetch("seq1", 32'h104, 1'b1);
    tick(); chk_fetch("seq2", 32'h108, 1'b1);

    // Same-cycle redirect with ack (unaligned target), then wrap at the top.
    icpu_ack_i = 1'b1; branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFE;
    chk_kill("redir_ack_kill", 1'b0);
    tick(); branch_taken = 1'b0;
    chk_fetch("top", 32'hFFFF_FFFC, 1'b1);
    tick(); chk_fetch("wrap", 32'h0000_0000, 1'b1);

    // Branch without ack -> DRAIN, late ack is killed.
    do_branch_ack(32'h200);
    chk_fetch("at200", 32'h200, 1'b1);
    icpu_ack_i = 1'b0; branch_taken = 1'b1; branch_addr = 32'h1003;
    tick(); branch_taken = 1'b0;
    chk_fetch("drain0", 32'h200, 1'b1);
    chk_kill("drain0_kill", 1'b0);
    tick(); chk_fetch("drain1", 32'h200, 1'b1);
    icpu_ack_i = 1'b1;
    chk_kill("drain_kill", 1'b1);
    tick(); chk_fetch("after_drain", 32'h1000, 1'b1);
    chk_kill("after_drain_kill", 1'b0);

    // Refetch holds pc with ack.
    genpc_refetch = 1'b1;
    tick(); genpc_refetch = 1'b0;
    chk_fetch("refetch", 32'h1000, 1'b1);

    // Freeze with ack for 3 cycles -> HOLD, then advance.
    do_branch_ack(32'h300);
    chk_fetch("at300", 32'h300, 1'b1);
    genpc_freeze = 1'b1;
    tick(); icpu_ack_i = 1'b0;
    chk_fetch("frz0", 32'h300, 1'b0);
    tick(); chk_fetch("frz1", 32'h300, 1'b0);
    tick(); chk_fetch("frz2", 32'h300, 1'b0);
    genpc_freeze = 1'b0;
    tick(); chk_fetch("unfrz", 32'h304, 1'b1);

    // Error -> HOLD indefinitely; ack ignored; exception leaves.
    do_branch_ack(32'h400);
    icpu_ack_i = 1'b0; icpu_err_i = 1'b1;
    tick(); icpu_err_i = 1'b0;
    chk_fetch("err0", 32'h400, 1'b0);
    tick(); tick(); chk_fetch("err2", 32'h400, 1'b0);
    icpu_ack_i = 1'b1;
    tick(); icpu_ack_i = 1'b0;
    chk_fetch("err_ack_ign", 32'h400, 1'b0);
    except_start = 1'b1; except_vector = 32'h600;
    tick(); except_start = 1'b0;
    chk_fetch("exc600", 32'h600, 1'b1);

    // ack and err together count as err.
    icpu_ack_i = 1'b1; icpu_err_i = 1'b1;
    tick(); icpu_ack_i = 1'b0; icpu_err_i = 1'b0;
    chk_fetch("ackerr", 32'h600, 1'b0);
    except_start = 1'b1; except_vector = 32'h700;
    tick(); except_start = 1'b0;
    chk_fetch("exc700", 32'h700, 1'b1);

    // DRAIN: exception outranks simultaneous branch and overwrites stored target.
    branch_taken = 1'b1; branch_addr = 32'h800;
    tick();
    branch_addr = 32'h900; except_start = 1'b1; except_vector = 32'hA00;
    tick(); branch_taken = 1'b0; except_start = 1'b0;
    chk_fetch("drain_pri", 32'h700, 1'b1);
    icpu_ack_i = 1'b1;
    chk_kill("drain_pri_kill", 1'b1);
    tick(); chk_fetch("pri_exc", 32'hA00, 1'b1);

    // DRAIN with ack plus new redirect in the same cycle.
    icpu_ack_i = 1'b0; branch_taken = 1'b1; branch_addr = 32'hB00;
    tick();
    icpu_ack_i = 1'b1; branch_addr = 32'hC00;
    chk_kill("drain_new_kill", 1'b1);
    tick(); branch_taken = 1'b0;
    chk_fetch("drain_new", 32'hC00, 1'b1);

    // Reset during DRAIN discards the stored target.
    icpu_ack_i = 1'b0; branch_taken = 1'b1; branch_addr = 32'hD00;
    tick(); branch_taken = 1'b0;
    rst = 1'b1; icpu_ack_i = 1'b1;
    chk_kill("rst_drain_kill", 1'b0);
    tick();
    chk_fetch("rst_drain", 32'h100, 1'b0);
    rst = 1'b0; icpu_ack_i = 1'b0;
    tick(); chk_fetch("rst_drain_req", 32'h100, 1'b1);
    icpu_ack_i = 1'b1;
    tick(); chk_fetch("rst_drain_seq", 32'h104, 1'b1);

    // Redirect in IDLE loads its target.
    rst = 1'b1; icpu_ack_i = 1'b0;
    tick(); rst = 1'b0;
    branch_taken = 1'b1; branch_addr = 32'h2000;
    tick(); branch_taken = 1'b0;
    chk_fetch("idle_redir", 32'h2000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
